// File: rtl/vga_line_fetch.sv
// Prefetches one 160-cell sand-grid row per four scanlines into a ping-pong
// line buffer and presents the registered grid word and cell type under the beam.
module vga_line_fetch #(
   parameter int HACTIVE   = 1280,
   parameter int HTOTAL    = 1600,
   parameter int VACTIVE   = 480,
   parameter int ROWS      = 120,
   parameter int WORDS     = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic        mem_req,
   output logic [10:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [31:0] word_out,
   output logic [1:0]  cell_t,
   output logic        underrun
);

   localparam int               IDX_W    = $clog2(WORDS);
   localparam logic [10:0]      H_ACT    = 11'(HACTIVE);
   localparam logic [10:0]      H_LAST   = 11'(HTOTAL - 1);
   localparam logic [9:0]       V_ACT    = 10'(VACTIVE);
   localparam logic [6:0]       ROW_LAST = 7'(ROWS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
   localparam logic [10:0]      BASE     = 11'(BASE_ADDR);
   localparam logic [10:0]      WORDS_A  = 11'(WORDS);
   localparam logic [3:0]       WIDX_LIM = 4'(WORDS);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [31:0]      bank [2][WORDS];
   logic [1:0]       bank_valid;
   logic             front_sel;
   logic             back_sel;
   logic [6:0]       fetch_row;
   logic [6:0]       row_nxt;
   logic [IDX_W-1:0] idx;
   logic             pending;
   logic             trigger, swap, wr_en, final_wr, back_full, fetch_active, abort;
   logic [3:0]       word_idx;
   logic [31:0]      word_nxt;
   logic [1:0]       cell_nxt;

   assign back_sel = ~front_sel;
   assign word_idx = hcount[10:7];

   // Frame events; the final word landing on the swap cycle counts as complete.
   always_comb begin
      trigger      = (hcount == '0) && (vcount < V_ACT) && (vcount[1:0] == 2'd0);
      swap         = (hcount == H_LAST) && (vcount < V_ACT) && (vcount[1:0] == 2'd3);
      wr_en        = (state == WAIT) && mem_rvalid;
      final_wr     = wr_en && (idx == IDX_LAST);
      back_full    = bank_valid[back_sel] || final_wr;
      fetch_active = (state == REQ) || (state == WAIT);
      abort        = swap && fetch_active && !back_full;
      row_nxt      = (vcount[8:2] == ROW_LAST) ? 7'd0 : vcount[8:2] + 7'd1;
   end

   // A trigger seen while draining is remembered so the next row still gets fetched
   // without ever having two reads in flight.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (trigger) state_nxt = REQ;
         REQ: begin
            if (abort)        state_nxt = mem_gnt ? DRAIN : IDLE;
            else if (mem_gnt) state_nxt = WAIT;
         end
         WAIT: begin
            if (abort)           state_nxt = mem_rvalid ? IDLE : DRAIN;
            else if (final_wr)   state_nxt = swap ? IDLE : DONE;
            else if (mem_rvalid) state_nxt = REQ;
         end
         DONE:  if (swap) state_nxt = IDLE;
         DRAIN: if (mem_rvalid) state_nxt = (pending || trigger) ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_req  = (state == REQ);
   assign mem_addr = mem_req ? (BASE + ({4'd0, fetch_row} * WORDS_A) + 11'(idx)) : 11'd0;

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bank_valid <= 2'b00;
         front_sel  <= 1'b0;
         fetch_row  <= 7'd0;
         idx        <= '0;
         pending    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (trigger && (state == IDLE || state == DRAIN)) begin
            fetch_row            <= row_nxt;
            idx                  <= '0;
            bank_valid[back_sel] <= 1'b0;
         end
         if (state == DRAIN) begin
            if (mem_rvalid)   pending <= 1'b0;
            else if (trigger) pending <= 1'b1;
         end
         if (wr_en) begin
            idx <= idx + IDX_W'(1);
            if (final_wr) bank_valid[back_sel] <= 1'b1;
         end
         if (swap) begin
            front_sel             <= back_sel;
            bank_valid[back_sel]  <= back_full;
            bank_valid[front_sel] <= 1'b0;
         end
         if (abort) underrun <= 1'b1;
      end
   end

   always_ff @(posedge clk50) begin
      if (wr_en) bank[back_sel][idx] <= mem_rdata;
   end

   always_comb begin
      word_nxt = '0;
      if ((hcount < H_ACT) && (vcount < V_ACT) && bank_valid[front_sel] && (word_idx < WIDX_LIM))
         word_nxt = bank[front_sel][word_idx];
      cell_nxt = word_nxt[{hcount[6:3], 1'b0} +: 2];
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         word_out <= '0;
         cell_t   <= '0;
      end else begin
         word_out <= word_nxt;
         cell_t   <= cell_nxt;
      end
   end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Drives compressed scanline timing and a randomized memory responder, and compares
// the line fetch against a row-level model of what the renderer should see.
module tb_vga_line_fetch;

   localparam int HACTIVE   = 1280;
   localparam int HTOTAL    = 1600;
   localparam int VACTIVE   = 480;
   localparam int ROWS      = 120;
   localparam int WORDS     = 10;
   localparam int BASE_ADDR = 0;

   logic        clk50 = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        mem_req;
   logic [10:0] mem_addr;
   logic        mem_gnt;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic [31:0] word_out;
   logic [1:0]  cell_t;
   logic        underrun;

   vga_line_fetch #(
      .HACTIVE(HACTIVE), .HTOTAL(HTOTAL), .VACTIVE(VACTIVE),
      .ROWS(ROWS), .WORDS(WORDS), .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk50(clk50), .reset(reset), .hcount(hcount), .vcount(vcount),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .word_out(word_out), .cell_t(cell_t), .underrun(underrun)
   );

   always #10 clk50 = ~clk50;

   logic [31:0] mem_img [2048];
   int checks = 0;
   int errors = 0;

   // Row-level view: what row the renderer is showing and how far the current fetch got.
   bit   front_ok;
   int   front_row;
   int   epoch;
   bit   fetch_open;
   int   fetch_row;
   int   delivered;
   int   addr_idx;
   bit   underrun_m;

   bit   outstanding;
   int   out_tag, out_addr, out_word_idx, lat_cnt;
   int   gnt_pct, lat_min, lat_max;
   int   stall_word, stall_len, stall_cnt;
   int   hold_word, hold_extra;
   bit   hold_to_swap;
   bit   drv_gnt, drv_rvalid;
   int   drv_h, drv_v, grant_addr, grant_idx;
   logic [31:0] exp_word;
   logic [1:0]  exp_cell;
   bit   decode_armed, reset_armed;
   int   rst_cycles;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (v=%0d h=%0d t=%0t)", tag, actual, expected, drv_v, drv_h, $time);
      end
   endtask

   function automatic logic [31:0] model_word(input int h, input int v);
      if (h >= HACTIVE || v >= VACTIVE || !front_ok) return 32'd0;
      return mem_img[BASE_ADDR + front_row * WORDS + h / 128];
   endfunction

   // Memory side: one read in flight, programmable grant odds, latency, stalls and holds.
   task automatic drive_memory(input int h, input int v);
      drv_gnt    = 1'b0;
      drv_rvalid = 1'b0;
      if (outstanding) begin
         check_output("req_busy", mem_req, 0);
         if (lat_cnt > 1) lat_cnt--;
         else if (out_word_idx == hold_word) begin
            if (hold_to_swap) begin
               if (h == HTOTAL - 1 && v % 4 == 3) begin drv_rvalid = 1'b1; hold_word = -1; end
            end else if (!(fetch_open && out_tag == epoch)) begin
               if (hold_extra > 0) hold_extra--;
               else begin drv_rvalid = 1'b1; hold_word = -1; end
            end
         end else drv_rvalid = 1'b1;
      end else if (mem_req) begin
         if (!fetch_open || addr_idx >= WORDS) check_output("req_idle", mem_req, 0);
         else begin
            check_output("mem_addr", mem_addr, BASE_ADDR + fetch_row * WORDS + addr_idx);
            if (stall_word == addr_idx && stall_cnt < stall_len) stall_cnt++;
            else drv_gnt = ($urandom_range(99) < gnt_pct);
            grant_addr = int'(mem_addr);
            grant_idx  = addr_idx;
         end
      end
      mem_gnt    = drv_gnt;
      mem_rvalid = drv_rvalid;
      mem_rdata  = drv_rvalid ? mem_img[out_addr] : $urandom;
   endtask

   task automatic clock_cycle(input int h, input int v);
      hcount   = 11'(h);
      vcount   = 10'(v);
      drv_h    = h;
      drv_v    = v;
      exp_word = model_word(h, v);
      exp_cell = 2'((exp_word >> (2 * ((h / 8) % 16))) & 32'd3);
      drive_memory(h, v);
      @(posedge clk50);
      @(negedge clk50);
      if (drv_rvalid) begin
         outstanding = 1'b0;
         if (fetch_open && out_tag == epoch) delivered++;
      end
      if (drv_gnt) begin
         outstanding  = 1'b1;
         out_tag      = epoch;
         out_addr     = grant_addr;
         out_word_idx = grant_idx;
         lat_cnt      = $urandom_range(lat_max, lat_min);
         addr_idx++;
      end
      if (h == HTOTAL - 1 && v < VACTIVE && v % 4 == 3) begin
         if (fetch_open) begin
            front_ok  = (delivered == WORDS);
            front_row = fetch_row;
            if (!front_ok) underrun_m = 1'b1;
         end else front_ok = 1'b0;
         fetch_open = 1'b0;
      end
      if (h == 0 && v < VACTIVE && v % 4 == 0) begin
         epoch++;
         fetch_open = 1'b1;
         fetch_row  = ((v / 4) + 1) % ROWS;
         delivered  = 0;
         addr_idx   = 0;
      end
      check_output("word_out", word_out, exp_word);
      check_output("cell_t", cell_t, exp_cell);
      check_output("underrun", underrun, underrun_m);
   endtask

   task automatic apply_reset_mid_fetch();
      check_output("req_before_rst", mem_req, 1);
      #3 reset = 1'b1;
      #1;
      check_output("rst_mem_req", mem_req, 0);
      check_output("rst_word_out", word_out, 0);
      check_output("rst_cell_t", cell_t, 0);
      check_output("rst_underrun", underrun, 0);
      front_ok    = 1'b0;
      fetch_open  = 1'b0;
      underrun_m  = 1'b0;
      outstanding = 1'b0;
      gnt_pct     = 60;
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b0;
      rst_cycles  = 2;
   endtask

   task automatic apply_stimulus(input int v, input int max_step);
      int h = 0;
      while (1) begin
         clock_cycle(h, v);
         if (rst_cycles > 0) begin
            rst_cycles--;
            if (rst_cycles == 0) reset = 1'b0;
         end
         if (decode_armed && v == 4 && h < 32 && h % 8 == 0)
            check_output("decode", cell_t, h / 8);
         if (reset_armed && h >= 200) begin
            reset_armed = 1'b0;
            apply_reset_mid_fetch();
         end
         if (h == HTOTAL - 1) break;
         h += $urandom_range(max_step, 1);
         if (h > HTOTAL - 1) h = HTOTAL - 1;
      end
   endtask

   task automatic configure(input int v);
      case (v)
         0:  begin gnt_pct = 100; lat_min = 2; lat_max = 2; end
         4:  begin gnt_pct = 60; lat_min = 1; lat_max = 4; end
         8:  begin stall_word = 4; stall_len = 50; stall_cnt = 0; end
         12: begin hold_word = 3; hold_to_swap = 1'b0; hold_extra = 3; end
         24: begin gnt_pct = 0; reset_armed = 1'b1; end
         28: begin hold_word = 9; hold_to_swap = 1'b1; end
         default: ;
      endcase
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem_img[i] = $urandom;
      mem_img[BASE_ADDR + 1 * WORDS] = 32'h000000E4;
      front_ok = 0; front_row = 0; epoch = 0; fetch_open = 0; fetch_row = 0;
      delivered = 0; addr_idx = 0; underrun_m = 0; outstanding = 0;
      out_tag = 0; out_addr = 0; out_word_idx = 0; lat_cnt = 0;
      gnt_pct = 60; lat_min = 1; lat_max = 4;
      stall_word = -1; stall_len = 0; stall_cnt = 0;
      hold_word = -1; hold_extra = 0; hold_to_swap = 0;
      drv_gnt = 0; drv_rvalid = 0; drv_h = 0; drv_v = 0; grant_addr = 0; grant_idx = 0;
      decode_armed = 1'b1; reset_armed = 1'b0; rst_cycles = 0;

      reset = 1'b1; hcount = 11'd5; vcount = 10'd500;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk50);
      @(negedge clk50);
      check_output("init_mem_req", mem_req, 0);
      check_output("init_mem_addr", mem_addr, 0);
      check_output("init_word_out", word_out, 0);
      check_output("init_cell_t", cell_t, 0);
      check_output("init_underrun", underrun, 0);
      reset = 1'b0;

      for (int v = 0; v < 36; v++) begin
         configure(v);
         apply_stimulus(v, (v == 4) ? 1 : 8);
      end
      decode_armed = 1'b0;

      gnt_pct = 60; lat_min = 1; lat_max = 4;
      for (int v = 472; v < 525; v++) apply_stimulus(v, (v >= VACTIVE) ? 64 : 8);
      for (int v = 0; v < 8; v++) apply_stimulus(v, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
